// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP32 multiplier scheduler and its response FIFO.
package fp_mul_pkg;

   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100
   } rmode_e;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

   // Response payload width excluding the requester id: product plus two flags.
   localparam int RSP_PAYLOAD_W = 34;

endpackage

// File: rtl/fp_mul_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy count; the head entry is
// presented combinationally whenever the FIFO is not empty.
module fp_mul_rsp_fifo
   import fp_mul_pkg::*;
#(
   parameter int WIDTH = 36,
   parameter int DEPTH = 5,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PW-1:0]               wr_ptr;
   logic [PW-1:0]               rd_ptr;
   logic                        do_wr;
   logic                        do_rd;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PW'(1);
      end
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == CW'(0));
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   // A write into an empty FIFO is only visible on the following cycle (no bypass).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_rd) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one fixed-latency FP32 multiplier among N_REQ requesters.
// Optional performance counters are enabled by defining FP_MUL_SCHED_PERF_EN.
module fp_mul_sched
   import fp_mul_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int MUL_LAT    = 3,
   parameter int FIFO_DEPTH = 5,
   localparam int IDW = $clog2(N_REQ),
   localparam int CW  = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ-1:0][31:0] req_x,
   input  logic [N_REQ-1:0][31:0] req_y,
   input  logic [N_REQ-1:0][2:0]  req_rmode,
   output logic                   mul_valid,
   output logic [31:0]            mul_x,
   output logic [31:0]            mul_y,
   output logic [2:0]             mul_rmode,
   input  logic [31:0]            mul_z,
   input  logic                   mul_ovrf,
   input  logic                   mul_udrf,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [31:0]            rsp_z,
   output logic                   rsp_ovrf,
   output logic                   rsp_udrf
`ifdef FP_MUL_SCHED_PERF_EN
   ,
   output logic [31:0]            perf_issued,
   output logic [31:0]            perf_stall
`endif
);

   localparam int FW = IDW + RSP_PAYLOAD_W;

   logic [IDW:0]                pick;
   logic [IDW-1:0]              winner;
   logic [IDW-1:0]              rr_ptr;
   logic [IDW-1:0]              issue_id;
   logic                        pop;
   logic                        accept;
   logic [CW-1:0]               credits;
   logic [MUL_LAT-1:0]          tag_valid;
   logic [MUL_LAT-1:0][IDW-1:0] tag_id;
   logic [FW-1:0]               fifo_rd;
   logic [CW-1:0]               fifo_count;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        unused_fifo_status;

   // Nearest valid requester at or after ptr (wrapping); MSB flags that one was found.
   function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] v, input logic [IDW-1:0] ptr);
      logic [IDW:0]   best;
      logic [IDW-1:0] idx;
      best = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = IDW'((int'(ptr) + k) % N_REQ);
         if (v[idx]) begin
            best = {1'b1, idx};
         end else begin
            best = best;
         end
      end
      return best;
   endfunction

   // A pop in the same cycle frees a slot, so a grant is allowed even at zero credits.
   always_comb begin
      pick      = rr_pick(req_valid, rr_ptr);
      winner    = pick[IDW-1:0];
      pop       = rsp_valid & rsp_ready;
      accept    = pick[IDW] & ((credits != CW'(0)) | pop) & ~rst;
      req_ready = '0;
      if (accept) begin
         req_ready[winner] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_valid <= 1'b0;
         mul_x     <= '0;
         mul_y     <= '0;
         mul_rmode <= RNE;
         issue_id  <= '0;
         rr_ptr    <= '0;
      end else begin
         mul_valid <= accept;
         if (accept) begin
            mul_x     <= req_x[winner];
            mul_y     <= req_y[winner];
            mul_rmode <= req_rmode[winner];
            issue_id  <= winner;
            rr_ptr    <= (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);
         end
      end
   end

   // Tag pipe mirrors the multiplier latency so the tail lines up with mul_z.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_valid <= '0;
         tag_id    <= '0;
      end else begin
         tag_valid[0] <= mul_valid;
         tag_id[0]    <= issue_id;
         for (int k = 1; k < MUL_LAT; k++) begin
            tag_valid[k] <= tag_valid[k-1];
            tag_id[k]    <= tag_id[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits <= CW'(FIFO_DEPTH);
      end else begin
         case ({accept, pop})
            2'b10:   credits <= credits - CW'(1);
            2'b01:   credits <= credits + CW'(1);
            default: credits <= credits;
         endcase
      end
   end

   fp_mul_rsp_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (tag_valid[MUL_LAT-1]),
      .wr_data ({tag_id[MUL_LAT-1], mul_z, mul_ovrf, mul_udrf}),
      .rd_en   (pop),
      .rd_data (fifo_rd),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign rsp_valid          = ~fifo_empty;
   assign rsp_id             = fifo_rd[FW-1 -: IDW];
   assign rsp_z              = fifo_rd[33:2];
   assign rsp_ovrf           = fifo_rd[1];
   assign rsp_udrf           = fifo_rd[0];
   assign unused_fifo_status = ^{fifo_count, fifo_full};

`ifdef FP_MUL_SCHED_PERF_EN
   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issued <= 32'd0;
         perf_stall  <= 32'd0;
      end else begin
         if (accept && (perf_issued != 32'hFFFF_FFFF)) begin
            perf_issued <= perf_issued + 32'd1;
         end
         if ((|req_valid) && (credits == CW'(0)) && (perf_stall != 32'hFFFF_FFFF)) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fp_mul_sched.sv
// Self-checking bench for fp_mul_sched: directed scenarios plus randomized traffic
// checked against a queue-based reference model and a behavioural multiplier stub.
`timescale 1ns/1ps
module tb_fp_mul_sched;
   import fp_mul_pkg::*;

   localparam int N_REQ      = 4;
   localparam int MUL_LAT    = 3;
   localparam int FIFO_DEPTH = 5;
   localparam int IDW        = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ-1:0][31:0] req_x;
   logic [N_REQ-1:0][31:0] req_y;
   logic [N_REQ-1:0][2:0]  req_rmode;
   logic                   mul_valid;
   logic [31:0]            mul_x;
   logic [31:0]            mul_y;
   logic [2:0]             mul_rmode;
   logic [31:0]            mul_z;
   logic                   mul_ovrf;
   logic                   mul_udrf;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [31:0]            rsp_z;
   logic                   rsp_ovrf;
   logic                   rsp_udrf;
`ifdef FP_MUL_SCHED_PERF_EN
   logic [31:0]            perf_issued;
   logic [31:0]            perf_stall;
`endif

   fp_mul_sched #(
      .N_REQ      (N_REQ),
      .MUL_LAT    (MUL_LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_rmode (req_rmode),
      .mul_valid (mul_valid),
      .mul_x     (mul_x),
      .mul_y     (mul_y),
      .mul_rmode (mul_rmode),
      .mul_z     (mul_z),
      .mul_ovrf  (mul_ovrf),
      .mul_udrf  (mul_udrf),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_z     (rsp_z),
      .rsp_ovrf  (rsp_ovrf),
      .rsp_udrf  (rsp_udrf)
`ifdef FP_MUL_SCHED_PERF_EN
      ,
      .perf_issued (perf_issued),
      .perf_stall  (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Truncating FP32 multiply stub: returns {z, ovrf, udrf}; zero/subnormal inputs give signed zero.
   function automatic logic [33:0] mul_stub(input logic [31:0] a, input logic [31:0] b);
      fp32_t       fa;
      fp32_t       fb;
      logic        s;
      int          e;
      logic [47:0] p;
      logic [22:0] f;
      logic [7:0]  eb;
      fa = a;
      fb = b;
      s  = fa.sign ^ fb.sign;
      if (fa.exp == 8'd0 || fb.exp == 8'd0) return {s, 31'd0, 2'b00};
      p = {1'b1, fa.frac} * {1'b1, fb.frac};
      e = int'(fa.exp) + int'(fb.exp) - 127;
      if (p[47]) begin
         e = e + 1;
         f = p[46:24];
      end else begin
         f = p[45:23];
      end
      if (e >= 255) return {s, 8'hFF, 23'd0, 2'b10};
      if (e <= 0) return {s, 31'd0, 2'b01};
      eb = 8'(e);
      return {s, eb, f, 2'b00};
   endfunction

   // External multiplier: fixed MUL_LAT pipeline, never reset, always driving a value.
   logic [33:0] mpipe [MUL_LAT];
   always @(posedge clk) begin
      mpipe[0] <= mul_stub(mul_x, mul_y);
      for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
   end
   assign mul_z    = mpipe[MUL_LAT-1][33:2];
   assign mul_ovrf = mpipe[MUL_LAT-1][1];
   assign mul_udrf = mpipe[MUL_LAT-1][0];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   typedef struct {
      int          id;
      logic [31:0] z;
      logic        ovrf;
      logic        udrf;
      int          avail;
   } exp_t;

   exp_t        pend[$];
   exp_t        fq[$];
   int          m_rr = 0;
   logic        m_mulv = 1'b0;
   logic [31:0] m_x = 32'd0;
   logic [31:0] m_y = 32'd0;
   logic [2:0]  m_rm = 3'd0;
   int          m_issued = 0;
   int          m_stall = 0;

   // Reference model: checks each cycle at the falling edge, then advances its state.
   initial begin : monitor
      int               credits;
      int               win;
      int               idx;
      logic [N_REQ-1:0] exp_ready;
      logic             pop;
      logic [33:0]      p;
      exp_t             e;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend.delete();
            fq.delete();
            m_rr     = 0;
            m_mulv   = 1'b0;
            m_issued = 0;
            m_stall  = 0;
         end else begin
            while (pend.size() > 0 && pend[0].avail <= cyc) fq.push_back(pend.pop_front());
            credits = FIFO_DEPTH - pend.size() - fq.size();
            chk("fifo_no_overflow", {63'd0, dut.u_fifo.full & dut.u_fifo.wr_en}, 64'd0);
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, fq.size() > 0});
            pop = (fq.size() > 0) && rsp_ready;
            if (fq.size() > 0) begin
               chk("rsp_id", {62'd0, rsp_id}, 64'(fq[0].id));
               chk("rsp_z", {32'd0, rsp_z}, {32'd0, fq[0].z});
               chk("rsp_flags", {62'd0, rsp_ovrf, rsp_udrf}, {62'd0, fq[0].ovrf, fq[0].udrf});
            end
            win = -1;
            for (int k = 0; k < N_REQ; k++) begin
               idx = (m_rr + k) % N_REQ;
               if (win < 0 && req_valid[idx]) win = idx;
            end
            exp_ready = '0;
            if (win >= 0 && (credits > 0 || pop)) exp_ready[win] = 1'b1;
            chk("req_ready", {60'd0, req_ready}, {60'd0, exp_ready});
            chk("mul_valid", {63'd0, mul_valid}, {63'd0, m_mulv});
            if (m_mulv) begin
               chk("mul_x", {32'd0, mul_x}, {32'd0, m_x});
               chk("mul_y", {32'd0, mul_y}, {32'd0, m_y});
               chk("mul_rmode", {61'd0, mul_rmode}, {61'd0, m_rm});
            end
            if ((|req_valid) && credits == 0) m_stall++;
            if (pop) void'(fq.pop_front());
            m_mulv = (exp_ready != '0);
            if (m_mulv) begin
               m_x     = req_x[win];
               m_y     = req_y[win];
               m_rm    = req_rmode[win];
               p       = mul_stub(m_x, m_y);
               e.id    = win;
               e.z     = p[33:2];
               e.ovrf  = p[1];
               e.udrf  = p[0];
               e.avail = cyc + 2 + MUL_LAT;
               pend.push_back(e);
               m_rr = (win + 1) % N_REQ;
               m_issued++;
            end
         end
      end
   end

   task automatic cyc_next();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
      req_valid[i] = 1'b1;
      req_x[i]     = x;
      req_y[i]     = y;
      req_rmode[i] = rm;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'h7F80_0000;
         3:       return FP32_QNAN;
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_ops();
      for (int i = 0; i < N_REQ; i++) begin
         req_x[i]     = pick_operand();
         req_y[i]     = pick_operand();
         req_rmode[i] = 3'($urandom_range(0, 4));
      end
   endtask

   task automatic wait_rsp(output int at);
      at = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            at = cyc;
            break;
         end
      end
   endtask

   initial begin : stim
      int t0;
      int at;
      int n_acc;
      int n_rsp;
      rst       = 1'b1;
      req_valid = '0;
      req_x     = '0;
      req_y     = '0;
      req_rmode = '0;
      rsp_ready = 1'b0;
      repeat (3) cyc_next();
      @(negedge clk);
      chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
      chk("rst_mul_valid", {63'd0, mul_valid}, 64'd0);
      chk("rst_mul_xy", {mul_x, mul_y}, 64'd0);
      chk("rst_mul_rmode", {61'd0, mul_rmode}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_payload", {28'd0, rsp_id, rsp_z, rsp_ovrf, rsp_udrf}, 64'd0);
      cyc_next();
      rst = 1'b0;
      cyc_next();

      // Single op from requester 0: 3.0 * 3.0, RTZ.
      rsp_ready = 1'b1;
      set_req(0, 32'h4040_0000, 32'h4040_0000, 3'b001);
      @(negedge clk);
      t0 = cyc;
      chk("t1_grant", {60'd0, req_ready}, 64'h1);
      cyc_next();
      req_valid = '0;
      @(negedge clk);
      chk("t1_mul_valid", {63'd0, mul_valid}, 64'd1);
      chk("t1_mul_x", {32'd0, mul_x}, 64'h4040_0000);
      chk("t1_mul_rmode", {61'd0, mul_rmode}, 64'h1);
      wait_rsp(at);
      chk("t1_latency", 64'(at - t0), 64'd5);
      chk("t1_rsp_id", {62'd0, rsp_id}, 64'd0);
      chk("t1_rsp_z", {32'd0, rsp_z}, 64'h4110_0000);
      chk("t1_rsp_flags", {62'd0, rsp_ovrf, rsp_udrf}, 64'd0);
      cyc_next();

      // Accept from requester 3 alone so the pointer wraps to 0.
      set_req(3, $urandom, $urandom, 3'b000);
      cyc_next();
      req_valid = '0;
      repeat (10) cyc_next();

      // All requesters valid with rsp_ready high: strict rotation at full rate.
      req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         rand_ops();
         @(negedge clk);
         chk("t2_order", {60'd0, req_ready}, 64'(1 << (k % 4)));
         cyc_next();
      end
      req_valid = '0;
      repeat (15) cyc_next();

      // Consumer stalled: exactly FIFO_DEPTH accepts, then one pop lets one more in.
      rsp_ready = 1'b0;
      req_valid = '1;
      rand_ops();
      n_acc = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (req_ready != '0) n_acc++;
         cyc_next();
      end
      chk("t3_accepts", 64'(n_acc), 64'd5);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t3_pop_reenable", 64'($countones(req_ready)), 64'd1);
      cyc_next();
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("t3_reblock", {60'd0, req_ready}, 64'd0);
      cyc_next();
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (15) cyc_next();

      // Signed-zero product passes through untouched.
      set_req(2, 32'h0000_0000, 32'hC000_0000, 3'b000);
      @(negedge clk);
      t0 = cyc;
      cyc_next();
      req_valid = '0;
      wait_rsp(at);
      chk("t4_latency", 64'(at - t0), 64'd5);
      chk("t4_rsp_id", {62'd0, rsp_id}, 64'd2);
      chk("t4_rsp_z", {32'd0, rsp_z}, 64'h8000_0000);
      cyc_next();
      repeat (5) cyc_next();

      // Reset with three ops in flight: nothing comes back, credits are restored.
      req_valid = '1;
      rand_ops();
      repeat (3) cyc_next();
      req_valid = '0;
      rst = 1'b1;
      cyc_next();
      rst = 1'b0;
      n_rsp = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid) n_rsp++;
         cyc_next();
      end
      chk("t5_no_rsp", 64'(n_rsp), 64'd0);
      set_req(1, 32'h3FC0_0000, 32'h4000_0000, 3'b011);
      @(negedge clk);
      t0 = cyc;
      chk("t5_grant", {60'd0, req_ready}, 64'h2);
      cyc_next();
      req_valid = '0;
      wait_rsp(at);
      chk("t5_latency", 64'(at - t0), 64'd5);
      chk("t5_rsp_id", {62'd0, rsp_id}, 64'd1);
      chk("t5_rsp_z", {32'd0, rsp_z}, 64'h4040_0000);
      cyc_next();
      repeat (3) cyc_next();
      rsp_ready = 1'b0;
      req_valid = '1;
      n_acc = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (req_ready != '0) n_acc++;
         cyc_next();
      end
      chk("t5_credits", 64'(n_acc), 64'd5);
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (15) cyc_next();

      // Randomized traffic with a randomly throttled consumer.
      for (int k = 0; k < 400; k++) begin
         req_valid = 4'($urandom_range(0, 15));
         rand_ops();
         rsp_ready = ($urandom_range(0, 3) != 0);
         cyc_next();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (20) cyc_next();
      @(negedge clk);
      chk("drain_empty", {63'd0, rsp_valid}, 64'd0);
`ifdef FP_MUL_SCHED_PERF_EN
      chk("perf_issued", {32'd0, perf_issued}, 64'(m_issued));
      chk("perf_stall", {32'd0, perf_stall}, 64'(m_stall));
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
